// File: rtl/cnn_frame_host.sv
// Host-side driver for the CNN classifier core: streams one frame into the core's
// database port, pulses GO, waits for the STOP handshake and returns the class.
module cnn_frame_host #(
    parameter int SIZE_1      = 11,
    parameter int SIZE_ADDR   = 13,
    parameter int PIC_SIZE    = 28,
    parameter int GO_CYCLES   = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [SIZE_1-1:0]    s_data,
    input  logic                        s_last,
    output logic                        we_database,
    output logic signed [SIZE_1-1:0]    dp_database,
    output logic [SIZE_ADDR-1:0]        address_p_database,
    output logic                        GO,
    input  logic                        STOP,
    input  logic [3:0]                  RESULT,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [3:0]                  res_class,
    output logic                        res_timeout,
    output logic                        err_len,
    output logic                        busy,
    output logic [2:0]                  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; valid never waits on ready, and ready depends only on the state.

    localparam int NUM_PIX = PIC_SIZE * PIC_SIZE;
    localparam int CNT_W   = 10;
    localparam int TMO_W   = 24;
    localparam int GO_W    = 4;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GO_W-1:0]  GO_LEN   = GO_W'(GO_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_GO_PULSE  = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_RESULT    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic                     we_q, we_d;
    logic signed [SIZE_1-1:0] dp_q, dp_d;
    logic [SIZE_ADDR-1:0]     addr_q, addr_d;
    logic [GO_W-1:0]          go_cnt_q, go_cnt_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [3:0]               res_class_q, res_class_d;
    logic                     res_to_q, res_to_d;
    logic                     err_len_q, err_len_d;

    logic s_hs;
    logic last_pix;
    logic tmo_hit;

    assign s_hs     = s_valid & s_ready;
    assign last_pix = (pix_cnt_q == LAST_PIX);
    // The counter reaches TIMEOUT_CYC on the edge that leaves the wait state.
    assign tmo_hit  = (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (s_hs && last_pix) begin
                    state_d = S_GO_PULSE;
                end
            end
            S_GO_PULSE: begin
                if (go_cnt_q == GO_LEN) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (tmo_hit || !STOP) begin
                    state_d = tmo_hit ? S_RESULT : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (tmo_hit || STOP) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == S_LOAD);
        GO        = (state_q == S_GO_PULSE) && (go_cnt_q != '0);
        res_valid = (state_q == S_RESULT);
        busy      = !((state_q == S_LOAD) && (pix_cnt_q == '0));
        dbg_state = state_q;
    end

    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        we_d        = 1'b0;
        dp_d        = dp_q;
        addr_d      = addr_q;
        go_cnt_d    = '0;
        tmo_d       = tmo_q;
        res_class_d = res_class_q;
        res_to_d    = res_to_q;
        err_len_d   = err_len_q;
        case (state_q)
            S_LOAD: begin
                if (s_hs) begin
                    we_d   = 1'b1;
                    dp_d   = s_data;
                    addr_d = SIZE_ADDR'(pix_cnt_q);
                    if (last_pix) begin
                        if (!s_last) begin
                            err_len_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Short frame: drop it and restart at address 0.
                        err_len_d = 1'b1;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GO_PULSE: begin
                go_cnt_d = go_cnt_q + GO_W'(1);
                // Zero on the GO rise cycle, so tmo_q equals cycles elapsed since GO rose.
                tmo_d    = (go_cnt_q == '0) ? '0 : tmo_q + TMO_W'(1);
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit) begin
                    res_class_d = 4'hF;
                    res_to_d    = 1'b1;
                end else if ((state_q == S_WAIT_HIGH) && STOP) begin
                    res_class_d = RESULT;
                    res_to_d    = 1'b0;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_class_d = '0;
                    res_to_d    = 1'b0;
                    pix_cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q   <= '0;
            we_q        <= 1'b0;
            dp_q        <= '0;
            addr_q      <= '0;
            go_cnt_q    <= '0;
            tmo_q       <= '0;
            res_class_q <= '0;
            res_to_q    <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            we_q        <= we_d;
            dp_q        <= dp_d;
            addr_q      <= addr_d;
            go_cnt_q    <= go_cnt_d;
            tmo_q       <= tmo_d;
            res_class_q <= res_class_d;
            res_to_q    <= res_to_d;
            err_len_q   <= err_len_d;
        end
    end

    assign we_database        = we_q;
    assign dp_database        = dp_q;
    assign address_p_database = addr_q;
    assign res_class          = res_class_q;
    assign res_timeout        = res_to_q;
    assign err_len            = err_len_q;

endmodule

// File: tb/tb_cnn_frame_host.sv
// Directed bench for cnn_frame_host with a small behavioural model of the classifier
// core driving STOP/RESULT; TIMEOUT_CYC is shortened to 1000 clocks.
module tb_cnn_frame_host;

    localparam int NPIX = 784;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic signed [10:0] s_data;
    logic              s_last;
    logic              we_database;
    logic signed [10:0] dp_database;
    logic [12:0]       address_p_database;
    logic              GO;
    logic              STOP;
    logic [3:0]        RESULT;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_class;
    logic              res_timeout;
    logic              err_len;
    logic              busy;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [12:0] wr_addr_q[$];
    logic [10:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          go_cyc_q[$];
    int          rv_rise_cyc = -1;
    int          excl_bad = 0;
    logic        rv_prev = 1'b0;

    int          core_delay = 500;
    logic [3:0]  core_result = 4'd7;
    int          core_cnt = -1;

    cnn_frame_host #(
        .SIZE_1(11), .SIZE_ADDR(13), .PIC_SIZE(28), .GO_CYCLES(2), .TIMEOUT_CYC(1000)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .we_database(we_database), .dp_database(dp_database),
        .address_p_database(address_p_database),
        .GO(GO), .STOP(STOP), .RESULT(RESULT),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_timeout(res_timeout), .err_len(err_len), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log writes, GO cycles, result rise, and exclusivity of GO/we/res_valid
    always @(negedge clk) begin
        if (we_database) begin
            wr_addr_q.push_back(address_p_database);
            wr_data_q.push_back(dp_database);
            wr_cyc_q.push_back(cyc);
        end
        if (GO) go_cyc_q.push_back(cyc);
        if (res_valid && !rv_prev) rv_rise_cyc = cyc;
        rv_prev = res_valid;
        if ((int'(GO) + int'(we_database) + int'(res_valid)) > 1) excl_bad++;
    end

    // Core model: STOP low while GO is seen, high core_delay cycles after GO falls
    initial begin
        STOP = 1'b1;
        RESULT = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                STOP = 1'b1;
                core_cnt = -1;
            end else if (GO) begin
                STOP = 1'b0;
                core_cnt = 0;
            end else if (core_cnt >= 0) begin
                core_cnt++;
                if (core_delay >= 0 && core_cnt >= core_delay) begin
                    STOP = 1'b1;
                    RESULT = core_result;
                    core_cnt = -1;
                end
            end
        end
    end

    // Driver tasks
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        go_cyc_q.delete();
        rv_rise_cyc = -1;
    endtask

    task automatic send_frame(input int n, input int last_at, input bit rnd, output bit ok);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 20000) begin
            tick();
            guard++;
            if (rnd && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_last = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data = 11'(i % 1024);
                s_last = (i == last_at);
                if (s_ready) i++;
            end
        end
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_res(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Count of deviations from the expected write log: addresses 0..n-1, data i mod 1024
    function automatic int wr_errors(input int n);
        int e = 0;
        logic [10:0] ed;
        logic [12:0] ea;
        if (wr_addr_q.size() != n) e++;
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            ed = 11'(i % 1024);
            ea = 13'(i);
            if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({GO, we_database, res_valid, res_timeout, err_len, busy, s_ready} !== 7'b0000001 ||
            address_p_database !== 13'd0 || dp_database !== 11'sd0 || res_class !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%b addr=%0d dp=%0d cls=%0d expected ctl=0000001 addr=0 dp=0 cls=0",
                     {GO, we_database, res_valid, res_timeout, err_len, busy, s_ready},
                     address_p_database, dp_database, res_class);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got s_ready=%b busy=%b state=%0d expected 1 0 0", s_ready, busy, dbg_state);
        end
    endtask

    task automatic test_basic_frame;
        bit ok;
        int e;
        int exp_go0;
        int got_go0;
        clear_mon();
        core_delay = 500;
        core_result = 4'd7;
        send_frame(NPIX, NPIX - 1, 1'b0, ok);
        wait_res(3000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_res_valid: got no res_valid expected res_valid within 3000 cycles");
        end
        e = wr_errors(NPIX);
        n_cmp++;
        if (e !== 0) begin
            n_bad++;
            $display("FAIL basic_writes: got %0d bad of %0d writes expected 0 bad of 784", e, wr_addr_q.size());
        end
        exp_go0 = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] + 1 : -1;
        got_go0 = (go_cyc_q.size() > 0) ? go_cyc_q[0] : -2;
        n_cmp++;
        if (go_cyc_q.size() !== 2 || got_go0 !== exp_go0 ||
            (go_cyc_q.size() == 2 && go_cyc_q[1] !== got_go0 + 1)) begin
            n_bad++;
            $display("FAIL basic_go_pulse: got %0d GO cycles first at %0d expected 2 consecutive from %0d",
                     go_cyc_q.size(), got_go0, exp_go0);
        end
        n_cmp++;
        if (res_class !== 4'd7 || res_timeout !== 1'b0 || err_len !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_result: got cls=%0d to=%b err=%b expected cls=7 to=0 err=0",
                     res_class, res_timeout, err_len);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || res_class !== 4'd0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_release: got rv=%b cls=%0d s_ready=%b busy=%b expected 0 0 1 0",
                     res_valid, res_class, s_ready, busy);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int e;
        int unstable = 0;
        clear_mon();
        core_delay = 40;
        core_result = 4'd3;
        send_frame(NPIX, NPIX - 1, 1'b1, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stream: got frame not accepted expected 784 handshakes");
        end
        wait_res(2000, ok);
        e = wr_errors(NPIX);
        n_cmp++;
        if (e !== 0) begin
            n_bad++;
            $display("FAIL bp_writes: got %0d bad of %0d writes expected 0 bad of 784", e, wr_addr_q.size());
        end
        for (int k = 0; k < 20; k++) begin
            if (res_valid !== 1'b1 || res_class !== 4'd3 || res_timeout !== 1'b0) unstable++;
            tick();
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0 (cls=3 held)", unstable);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || res_class !== 4'd0) begin
            n_bad++;
            $display("FAIL bp_release: got rv=%b cls=%0d expected 0 0", res_valid, res_class);
        end
    endtask

    task automatic test_short_frame;
        bit ok;
        int e;
        clear_mon();
        send_frame(100, 99, 1'b0, ok);
        repeat (5) tick();
        e = wr_errors(100);
        n_cmp++;
        if (err_len !== 1'b1 || go_cyc_q.size() !== 0 || busy !== 1'b0 || e !== 0) begin
            n_bad++;
            $display("FAIL short_frame: got err=%b go=%0d busy=%b wr_bad=%0d expected 1 0 0 0",
                     err_len, go_cyc_q.size(), busy, e);
        end
        // Follow-up frame with res_ready already high: res_valid lasts one cycle
        clear_mon();
        core_delay = 30;
        core_result = 4'd9;
        res_ready = 1'b1;
        send_frame(NPIX, NPIX - 1, 1'b0, ok);
        wait_res(2000, ok);
        e = wr_errors(NPIX);
        n_cmp++;
        if (ok !== 1'b1 || res_class !== 4'd9 || e !== 0 || err_len !== 1'b1) begin
            n_bad++;
            $display("FAIL short_recover: got rv=%b cls=%0d wr_bad=%0d err=%b expected 1 9 0 1",
                     ok, res_class, e, err_len);
        end
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL short_one_cycle_rv: got rv=%b state=%0d expected 0 0", res_valid, dbg_state);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int got;
        clear_mon();
        core_delay = -1;
        send_frame(NPIX, NPIX - 1, 1'b0, ok);
        wait_res(1500, ok);
        got = (go_cyc_q.size() > 0 && rv_rise_cyc >= 0) ? rv_rise_cyc - go_cyc_q[0] : -1;
        n_cmp++;
        if (got !== 1000) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles expected 1000", got);
        end
        n_cmp++;
        if (res_class !== 4'hF || res_timeout !== 1'b1 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_result: got cls=%h to=%b rv=%b expected f 1 1", res_class, res_timeout, res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1 || res_valid !== 1'b0 || res_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_release: got s_ready=%b rv=%b to=%b expected 1 0 0", s_ready, res_valid, res_timeout);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int e;
        clear_mon();
        core_delay = -1;
        send_frame(NPIX, NPIX - 1, 1'b0, ok);
        for (int k = 0; k < 50 && dbg_state !== 3'd3; k++) tick();
        n_cmp++;
        if (dbg_state !== 3'd3) begin
            n_bad++;
            $display("FAIL abort_reach_wait_high: got state=%0d expected 3", dbg_state);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({GO, we_database, res_valid, res_timeout, err_len, busy, s_ready} !== 7'b0000001 ||
            address_p_database !== 13'd0 || dp_database !== 11'sd0 || res_class !== 4'd0) begin
            n_bad++;
            $display("FAIL abort_wait_high: got ctl=%b addr=%0d dp=%0d cls=%0d expected ctl=0000001 addr=0 dp=0 cls=0",
                     {GO, we_database, res_valid, res_timeout, err_len, busy, s_ready},
                     address_p_database, dp_database, res_class);
        end
        tick();
        rst = 1'b0;
        // Abort mid-frame after 400 pixels
        clear_mon();
        core_delay = 25;
        core_result = 4'd5;
        send_frame(400, -1, 1'b0, ok);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({GO, we_database, res_valid, err_len, busy, s_ready} !== 6'b000001 ||
            address_p_database !== 13'd0 || dp_database !== 11'sd0) begin
            n_bad++;
            $display("FAIL abort_mid_frame: got ctl=%b addr=%0d dp=%0d expected ctl=000001 addr=0 dp=0",
                     {GO, we_database, res_valid, err_len, busy, s_ready}, address_p_database, dp_database);
        end
        tick();
        rst = 1'b0;
        clear_mon();
        send_frame(NPIX, NPIX - 1, 1'b0, ok);
        wait_res(2000, ok);
        e = wr_errors(NPIX);
        n_cmp++;
        if (ok !== 1'b1 || e !== 0 || res_class !== 4'd5 || err_len !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_fresh_frame: got rv=%b wr_bad=%0d cls=%0d err=%b expected 1 0 5 0",
                     ok, e, res_class, err_len);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_exclusive;
        n_cmp++;
        if (excl_bad !== 0) begin
            n_bad++;
            $display("FAIL exclusive_go_we_rv: got %0d overlapping cycles expected 0", excl_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_short_frame();
        test_timeout();
        test_reset_abort();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running at 2ms expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cnn_frame_host.md
Name: cnn_frame_host

Overview:
- Host-side driver for the CNN classifier core; the other end of the core's database-load and GO/STOP/RESULT interface.
- Accepts a pixel stream (valid/ready, last), writes pixels into the core's database port at sequential addresses, and pulses GO.
- Waits for the core's STOP handshake, captures RESULT, and presents the class on a valid/ready result port.
- Sits between the frame source (camera/DMA) and the classifier core.

Parameters:
- SIZE_1, 11, pixel word width (signed), equal to the core's SIZE_1.
- SIZE_ADDR, 13, database address width.
- PIC_SIZE, 28, picture edge length; NUM_PIX = PIC_SIZE*PIC_SIZE = 784 words per frame.
- GO_CYCLES, 2, GO pulse length in clocks (1..15).
- TIMEOUT_CYC, 2000000, maximum clocks from the GO rising edge to STOP=1 (24-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel ready.
- s_data  in  SIZE_1  signed pixel.
- s_last  in  1  last pixel of frame.
- we_database  out  1  database write enable to core.
- dp_database  out  SIZE_1  database write data.
- address_p_database  out  SIZE_ADDR  database write address.
- GO  out  1  core start.
- STOP  in  1  core done (driven low by core while GO is seen, high when finished).
- RESULT  in  4  core class output (valid only while STOP=1).
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_class  out  4  captured class; 4'hF on timeout.
- res_timeout  out  1  qualifies res_class: core timed out.
- err_len  out  1  sticky: frame length / s_last mismatch seen.
- busy  out  1  high in every state except LOAD with pix_cnt=0.

Behaviour:
- Synchronous active-high reset on clk (already decided); single clock domain.
- Reset values: all outputs 0, address 0, state LOAD, pix_cnt 0, timeout counter 0, err_len cleared. Reset mid-frame or mid-inference aborts immediately; GO drops the next cycle.
- Reset aborts an inference in progress; the core is not otherwise notified.
- State LOAD:
  - s_ready=1.
  - On handshake (s_valid & s_ready), register we_database=1, dp_database=s_data, address_p_database=pix_cnt in the following cycle (1-cycle latency). we_database is high exactly one cycle per accepted pixel.
  - pix_cnt increments per handshake.
  - s_last with pix_cnt<NUM_PIX-1: set err_len, discard frame (pix_cnt=0), stay LOAD. Writes already issued are not undone.
  - Handshake at pix_cnt=NUM_PIX-1:
    - frame complete regardless of s_last;
    - if s_last=0, set err_len;
    - s_ready drops the next cycle;
    - go to GO_PULSE.
- GO_PULSE:
  - Entered the cycle the last write is on the port.
  - GO=1 starts the cycle after the last we_database and stays high exactly GO_CYCLES cycles.
  - Timeout counter cleared at GO rise and counts every cycle through WAIT_LOW and WAIT_HIGH.
  - Then go to WAIT_LOW.
- WAIT_LOW: wait STOP=0 (core acknowledged GO), then go to WAIT_HIGH. If STOP is already 0 on entry, leave next cycle.
- WAIT_HIGH:
  - On STOP=1, capture RESULT into res_class, res_timeout=0, go to RESULT.
- Timeout:
  - Counter reaching TIMEOUT_CYC in WAIT_LOW or WAIT_HIGH overrides STOP.
  - Action: res_class=4'hF, res_timeout=1, go to RESULT.
- RESULT:
  - res_valid=1; res_class and res_timeout held stable until res_ready.
  - Handshake (res_valid & res_ready): res_valid=0 next cycle, pix_cnt=0, go to LOAD.
  - If res_ready is high on entry, res_valid is high for exactly one cycle.
- s_ready=0 in all states except LOAD. Stream input is ignored outside LOAD.
- GO, we_database and res_valid are never high in the same cycle.
- err_len is cleared only by rst.
- Address width: pix_cnt is 10 bits, zero-extended to SIZE_ADDR. No wrap; the maximum address is NUM_PIX-1.

Test Plan:
- 784 pixels, s_data=i mod 1024 (sign-extended), s_last on 784th, core model STOP after 500 cycles with RESULT=7:
  - 784 writes, addresses 0..783;
  - GO high 2 cycles starting 1 cycle after the address-783 write;
  - res_valid with res_class=7, res_timeout=0, err_len=0.
- s_valid toggled randomly, res_ready held low 20 cycles:
  - no duplicated or dropped writes;
  - res_class stable while res_valid, cleared one cycle after res_ready.
- s_last asserted on pixel 100:
  - err_len=1, no GO;
  - next 784-pixel frame writes from address 0 and completes normally.
- Core model never raises STOP, TIMEOUT_CYC=1000:
  - res_valid exactly 1000 cycles after the GO rise;
  - res_class=4'hF, res_timeout=1; return to LOAD after res_ready.
- rst asserted during WAIT_HIGH and again at pixel 400:
  - all outputs 0 the next cycle, err_len cleared, s_ready=1;
  - a fresh frame restarts at address 0.
